retry_inorder_end: RTL

- Terminating end of the retry loop. Sits downstream of time_DMR_end and feeds the consumer.
- Each beat arrives tagged with an ID and a needs_retry flag:
  - Faulty beats become retry requests toward retry_start.
  - Good beats land in a reorder buffer indexed by ID.
- Output is strictly in ID order (retry_start issue order), so retries never reorder the stream.

---
 rtl/retry_pkg.sv | 27 ++
 rtl/retry_inorder_buffer.sv | 59 +++++
 rtl/retry_inorder_end.sv | 120 ++++++++++++
 3 files changed

// File: rtl/retry_pkg.sv
// retry_pkg: shared types and helpers for the retry loop blocks
// (retry_start, time_DMR_end, retry_inorder_end).
package retry_pkg;

  // Upper bound on the ID width the helpers below can handle.
  localparam int MaxIdSize = 8;

  // Occupancy of one reorder-buffer slot.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } entry_state_e;

  // Retry request carried from the terminating end back to retry_start.
  typedef struct packed {
    logic [MaxIdSize-1:0] id;
  } retry_req_t;

  // Wrapping increment of an ID living in a 2**id_size space.
  function automatic logic [MaxIdSize-1:0] id_inc(input logic [MaxIdSize-1:0] id,
                                                  input int unsigned           id_size);
    logic [MaxIdSize-1:0] mask;
    mask = MaxIdSize'((1 << id_size) - 1);
    return (id + 1'b1) & mask;
  endfunction

endpackage

// File: rtl/retry_inorder_buffer.sv
// retry_inorder_buffer: reorder storage indexed by ID. One EMPTY/FULL flag and
// one data word per slot, a write port, a read port at an arbitrary pointer
// and a clear port. Reads are combinational so a slot written on one edge is
// visible on the read port right after that edge.
module retry_inorder_buffer
  import retry_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int IDSize    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [IDSize-1:0]    wr_id_i,
  input  logic [DataWidth-1:0] wr_data_i,
  output logic                 wr_full_o,
  input  logic [IDSize-1:0]    rd_id_i,
  output logic                 rd_full_o,
  output logic [DataWidth-1:0] rd_data_o,
  input  logic                 clr_en_i,
  input  logic [IDSize-1:0]    clr_id_i
);

  localparam int Depth = 1 << IDSize;

  entry_state_e         r_state [Depth];
  logic [DataWidth-1:0] r_mem   [Depth];
  logic [Depth-1:0]     w_set;
  logic [Depth-1:0]     w_clr;

  // One-hot decode of the write and clear addresses.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_dec
    assign w_set[gi] = wr_en_i  && (wr_id_i  == IDSize'(gi));
    assign w_clr[gi] = clr_en_i && (clr_id_i == IDSize'(gi));
  end

  // Slot occupancy. The top only writes EMPTY slots and only clears FULL ones,
  // so set and clear never hit the same slot in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) r_state[i] <= EMPTY;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (w_set[i])      r_state[i] <= FULL;
        else if (w_clr[i]) r_state[i] <= EMPTY;
      end
    end
  end

  // Payload storage; contents are don't-care while a slot is EMPTY.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[wr_id_i] <= wr_data_i;
  end

  assign wr_full_o = (r_state[wr_id_i] == FULL);
  assign rd_full_o = (r_state[rd_id_i] == FULL);
  assign rd_data_o = r_mem[rd_id_i];

endmodule

// File: rtl/retry_inorder_end.sv
// retry_inorder_end: terminating end of the retry loop. Failed beats turn into
// retry requests, good beats are parked by ID and released strictly in ID
// order, so re-issued beats slot back into their original position.
// Optional macro RETRY_INORDER_STATS_EN adds saturating retry/duplicate counters.
module retry_inorder_end
  import retry_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int IDSize    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [IDSize-1:0]    id_i,
  input  logic                 needs_retry_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [IDSize-1:0]    retry_id_o,
  output logic                 retry_valid_o,
  input  logic                 retry_ready_i
`ifdef RETRY_INORDER_STATS_EN
  ,
  output logic [31:0]          retry_count_o,
  output logic [31:0]          dup_count_o
`endif
);

  logic [IDSize-1:0] r_expect;
  logic [IDSize-1:0] r_retry_id;
  logic              r_retry_valid;

  logic              w_in_fire;
  logic              w_bad_beat;
  logic              w_good_beat;
  logic              w_wr_full;
  logic              w_wr_en;
  logic              w_dup;
  logic              w_rd_full;
  logic              w_out_fire;
  logic              w_retry_fire;
  logic [IDSize-1:0] w_expect_next;

  // Only an unaccepted retry request holds off upstream.
  assign ready_o      = !(r_retry_valid && !retry_ready_i);
  assign w_in_fire    = valid_i && ready_o;
  assign w_bad_beat   = w_in_fire && needs_retry_i;
  assign w_good_beat  = w_in_fire && !needs_retry_i;
  // A good beat landing on an occupied slot (including the one being read
  // out this cycle) is a duplicate; the stored copy wins.
  assign w_wr_en      = w_good_beat && !w_wr_full;
  assign w_dup        = w_good_beat && w_wr_full;
  assign w_retry_fire = r_retry_valid && retry_ready_i;

  assign valid_o       = w_rd_full;
  assign w_out_fire    = w_rd_full && ready_i;
  assign w_expect_next = IDSize'(id_inc(MaxIdSize'(r_expect), IDSize));

  assign retry_valid_o = r_retry_valid;
  assign retry_id_o    = r_retry_id;

  retry_inorder_buffer #(
    .DataWidth (DataWidth),
    .IDSize    (IDSize)
  ) u_buffer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (w_wr_en),
    .wr_id_i   (id_i),
    .wr_data_i (data_i),
    .wr_full_o (w_wr_full),
    .rd_id_i   (r_expect),
    .rd_full_o (w_rd_full),
    .rd_data_o (data_o),
    .clr_en_i  (w_out_fire),
    .clr_id_i  (r_expect)
  );

  // Read pointer: advance (with wrap) each time the consumer takes a beat.
  always_ff @(posedge clk_i) begin
    if (rst_i)           r_expect <= '0;
    else if (w_out_fire) r_expect <= w_expect_next;
  end

  // Retry request register: a newly accepted failing beat takes precedence
  // over clearing on handshake, so back-to-back failures are not lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retry_valid <= 1'b0;
      r_retry_id    <= '0;
    end else if (w_bad_beat) begin
      r_retry_valid <= 1'b1;
      r_retry_id    <= id_i;
    end else if (w_retry_fire) begin
      r_retry_valid <= 1'b0;
    end
  end

`ifdef RETRY_INORDER_STATS_EN
  logic [31:0] r_retry_count;
  logic [31:0] r_dup_count;

  // Saturating event counters for failed beats and dropped duplicates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_retry_count <= '0;
      r_dup_count   <= '0;
    end else begin
      if (w_bad_beat && (r_retry_count != '1)) r_retry_count <= r_retry_count + 32'd1;
      if (w_dup && (r_dup_count != '1))        r_dup_count   <= r_dup_count + 32'd1;
    end
  end

  assign retry_count_o = r_retry_count;
  assign dup_count_o   = r_dup_count;
`endif

endmodule
